// File: rtl/gpio_input_debounce.sv
`default_nettype none
// ============================================================================
// Module   : gpio_input_debounce
// Brief    : Per-channel pin synchronizer and debounce FSM with press/release
//            pulses; optional sticky press events + irq under macro
//            GPIO_INPUT_DEBOUNCE_EVENT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_input_debounce #(
  parameter int NUM_CH          = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] btn_state,
  output logic [NUM_CH-1:0] btn_rise,
  output logic [NUM_CH-1:0] btn_fall,
  input  logic [NUM_CH-1:0] event_clr,
  output logic [NUM_CH-1:0] event_pending,
  output logic              irq
);

  localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [0:0] {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_t;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_cnt_w-1:0]     r_cnt;
    state_t                 r_fsm;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_pin;
    logic                   w_sync;

    assign w_pin  = (ACTIVE_LOW != 0) ? ~btn_in[gi] : btn_in[gi];
    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_sync  <= '0;
        r_cnt   <= '0;
        r_fsm   <= ST_STABLE;
        r_level <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_pin};
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        case (r_fsm)
          ST_STABLE: begin
            if (w_sync != r_level) begin
              // A one-cycle debounce accepts the change without a counting stay.
              if (DEBOUNCE_CYCLES == 1) begin
                r_level <= w_sync;
                r_rise  <= w_sync;
                r_fall  <= ~w_sync;
              end else begin
                r_fsm <= ST_COUNTING;
                r_cnt <= c_cnt_one;
              end
            end
          end
          ST_COUNTING: begin
            if (w_sync == r_level) begin
              r_fsm <= ST_STABLE;
              r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
              r_level <= w_sync;
              r_rise  <= w_sync;
              r_fall  <= ~w_sync;
              r_fsm   <= ST_STABLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end
          default: begin
            r_fsm <= ST_STABLE;
            r_cnt <= '0;
          end
        endcase
      end
    end

    assign btn_state[gi] = r_level;
    assign btn_rise[gi]  = r_rise;
    assign btn_fall[gi]  = r_fall;
  end

`ifdef GPIO_INPUT_DEBOUNCE_EVENT_EN
  logic [NUM_CH-1:0] r_event_pending;

  // Set from the registered press pulse; a set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_event_pending <= '0;
    end else begin
      r_event_pending <= btn_rise | (r_event_pending & ~event_clr);
    end
  end

  assign event_pending = r_event_pending;
  assign irq           = |r_event_pending;
`else
  logic w_unused_event_clr;

  assign w_unused_event_clr = ^event_clr;
  assign event_pending      = '0;
  assign irq                = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpio_input_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_input_debounce
// Brief    : Directed self-checking bench with a run-length behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_input_debounce;

  localparam int NUM_CH = 2;
  localparam int SYNC   = 2;
  localparam int DEB    = 4;
  localparam int HL     = SYNC + DEB;
`ifdef GPIO_INPUT_DEBOUNCE_EVENT_EN
  localparam bit EV_EN = 1'b1;
`else
  localparam bit EV_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              resetn = 1'b1;
  logic [NUM_CH-1:0] btn_in = 2'b11;
  logic [NUM_CH-1:0] event_clr = 2'b00;
  logic [NUM_CH-1:0] btn_state, btn_rise, btn_fall, event_pending;
  logic              irq;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  gpio_input_debounce #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .resetn(resetn), .btn_in(btn_in), .btn_state(btn_state),
    .btn_rise(btn_rise), .btn_fall(btn_fall), .event_clr(event_clr),
    .event_pending(event_pending), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: ph[k] is the pressed level sampled k edges ago. The debounce
  // logic sees samples SYNC edges late; the state flips once the DEB most
  // recent seen samples all disagree with it.
  logic [NUM_CH-1:0] ph [0:HL-1];
  logic [NUM_CH-1:0] m_state, m_rise, m_fall, m_ev, m_ev_nx;
  bit                all_diff;

  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        for (int k = 0; k < HL; k++) ph[k] = '0;
        m_state = '0; m_rise = '0; m_fall = '0; m_ev = '0;
      end else begin
        for (int k = HL - 1; k > 0; k--) ph[k] = ph[k-1];
        ph[0]   = ~btn_in;
        m_ev_nx = EV_EN ? (m_rise | (m_ev & ~event_clr)) : '0;
        m_rise  = '0;
        m_fall  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
          all_diff = 1'b1;
          for (int k = SYNC; k < HL; k++)
            if (ph[k][c] == m_state[c]) all_diff = 1'b0;
          if (all_diff) begin
            m_state[c] = ~m_state[c];
            if (m_state[c]) m_rise[c] = 1'b1;
            else            m_fall[c] = 1'b1;
          end
        end
        m_ev = m_ev_nx;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("state", btn_state, m_state);
        chk("rise", btn_rise, m_rise);
        chk("fall", btn_fall, m_fall);
        chk("pending", event_pending, m_ev);
        chk("irq", irq, |m_ev);
        chk("rise_fall_excl", btn_rise & btn_fall, 0);
      end
    end
  end

  initial begin
    // Reset asserted mid-clock: outputs clear without a clock edge.
    #12 resetn = 1'b0;
    cmp_en = 1'b1;
    #1;
    chk("rst_state", btn_state, 0);
    chk("rst_rise", btn_rise, 0);
    chk("rst_fall", btn_fall, 0);
    chk("rst_pending", event_pending, 0);
    chk("rst_irq", irq, 0);
    step(3);
    #2 resetn = 1'b1;
    step(20);
    chk("post_rst_state", btn_state, 0);
    chk("post_rst_irq", irq, 0);

    // Clean press on channel 0
    btn_in[0] = 1'b0;
    step(5);
    chk("press_early_state", btn_state, 2'b00);
    step(1);
    chk("press_state", btn_state, 2'b01);
    chk("press_rise", btn_rise, 2'b01);
    step(1);
    chk("press_rise_gone", btn_rise, 2'b00);
    chk("press_pending", event_pending, EV_EN ? 2'b01 : 2'b00);
    chk("press_irq", irq, EV_EN);

    // Release
    btn_in[0] = 1'b1;
    step(5);
    chk("rel_early_state", btn_state, 2'b01);
    step(1);
    chk("rel_state", btn_state, 2'b00);
    chk("rel_fall", btn_fall, 2'b01);
    chk("rel_pending", event_pending, EV_EN ? 2'b01 : 2'b00);
    step(2);

    // Bounce: low 3, high 1, then low held
    btn_in[0] = 1'b0; step(3);
    btn_in[0] = 1'b1; step(1);
    btn_in[0] = 1'b0;
    step(5);
    chk("bounce_early_state", btn_state, 2'b00);
    step(1);
    chk("bounce_state", btn_state, 2'b01);
    chk("bounce_rise", btn_rise, 2'b01);

    // Clear race: clear held across a new press
    btn_in[0] = 1'b1;
    step(8);
    event_clr[0] = 1'b1;
    btn_in[0]    = 1'b0;
    step(5);
    chk("clr_pre_pending", event_pending, 2'b00);
    step(1);
    chk("clr_rise", btn_rise, 2'b01);
    step(1);
    chk("clr_set_wins", event_pending, EV_EN ? 2'b01 : 2'b00);
    step(1);
    chk("clr_after", event_pending, 2'b00);
    event_clr[0] = 1'b0;

    // Reset in the middle of a count
    btn_in[0] = 1'b1;
    step(8);
    btn_in[0] = 1'b0;
    step(4);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_state", btn_state, 0);
    chk("midrst_rise", btn_rise, 0);
    step(1);
    #2 resetn = 1'b1;
    step(5);
    chk("midrst_early_state", btn_state, 2'b00);
    step(1);
    chk("midrst_rise_after", btn_rise, 2'b01);

    // Channel 1 bounces while channel 0 stays pressed
    btn_in[1] = 1'b0; step(2);
    btn_in[1] = 1'b1; step(1);
    btn_in[1] = 1'b0;
    step(5);
    chk("ch1_early_state", btn_state, 2'b01);
    step(1);
    chk("ch1_state", btn_state, 2'b11);
    chk("ch1_rise", btn_rise, 2'b10);
    btn_in = 2'b11;
    step(6);
    chk("both_fall", btn_fall, 2'b11);
    chk("both_state", btn_state, 2'b00);

    // Mixed patterns checked against the model only
    for (int i = 0; i < 24; i++) begin
      btn_in    = 2'($urandom_range(0, 3));
      event_clr = 2'($urandom_range(0, 3));
      step($urandom_range(1, 7));
    end
    btn_in = 2'b11;
    event_clr = 2'b00;
    step(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpio_input_debounce.md
GPIO_INPUT_DEBOUNCE -- requirements
Module: gpio_input_debounce

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth (minimum 2).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 500000: stable-clock count required before a level change is accepted (minimum 1); 10 ms at 50 MHz.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 = raw pin low means pressed; 0 = raw pin high means pressed.
REQ-005 SHALL have port clk, input, 1: single system clock; all state on rising edge.
REQ-006 SHALL have port resetn, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port btn_in, input, NUM_CH: raw asynchronous button pins.
REQ-008 SHALL have port btn_state, output, NUM_CH: debounced logical level, 1 = pressed.
REQ-009 SHALL have port btn_rise, output, NUM_CH: one-cycle pulse on accepted press.
REQ-010 SHALL have port btn_fall, output, NUM_CH: one-cycle pulse on accepted release.
REQ-011 SHALL have port event_clr, input, NUM_CH: per-channel clear of event_pending, level-sensitive.
REQ-012 SHALL have port event_pending, output, NUM_CH: sticky press-event flags.
REQ-013 SHALL have port irq, output, 1: OR of all event_pending bits.

Function
REQ-014 Each channel SHALL invert the raw pin when ACTIVE_LOW=1, then pass it through a SYNC_STAGES flop chain; the last stage is the channel's sync level.
REQ-015 Each channel SHALL run an independent two-state FSM, STABLE and COUNTING, with a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-016 In STABLE with sync == btn_state, the counter SHALL hold 0; when sync != btn_state, the FSM SHALL go to COUNTING with the counter at 1.
REQ-017 In COUNTING with sync != btn_state, the counter SHALL increment; the edge at which it would reach DEBOUNCE_CYCLES SHALL instead toggle btn_state, clear the counter and return to STABLE.
REQ-018 In COUNTING, if sync returns to btn_state, the counter SHALL clear and the FSM SHALL return to STABLE with no output change (bounce rejection).
REQ-019 With DEBOUNCE_CYCLES=1, btn_state SHALL toggle on the first edge at which sync differs (no COUNTING residency).
REQ-020 Total latency from a held pin change to btn_state change SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES clocks after the first sampling edge.
REQ-021 btn_rise/btn_fall SHALL be registered and asserted for exactly the one cycle in which btn_state shows its new value; they SHALL never both be high on one channel.
REQ-022 event_pending[i] SHALL set on btn_rise[i] and clear while event_clr[i]=1; a simultaneous set and clear SHALL leave it set.
REQ-023 irq SHALL be the combinational OR of the registered event_pending bits.
REQ-024 Counters SHALL never wrap; channels SHALL not interact.

Reset
REQ-025 While resetn=0, all synchronizer flops, btn_state, counters, btn_rise, btn_fall and event_pending SHALL be 0, the FSM SHALL be STABLE, and irq SHALL be 0, regardless of clk.
REQ-026 Reset asserted mid-count SHALL discard the count and produce no pulse; after release, a held pressed pin SHALL be accepted after the full REQ-020 latency.

Configuration
REQ-027 Macro GPIO_INPUT_DEBOUNCE_EVENT_EN defined: event_pending, event_clr and irq SHALL behave per REQ-022/023.
REQ-028 Macro GPIO_INPUT_DEBOUNCE_EVENT_EN undefined: event_pending and irq SHALL be tied to 0, event_clr SHALL be ignored and no event flops SHALL be synthesized; all other behaviour SHALL be unchanged.

Verification (NUM_CH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, EVENT_EN defined)
REQ-029 Reset: btn_in=2'b11, assert resetn=0 mid-clock -> all outputs 0 immediately; after release, outputs stay 0 for 20 cycles.
REQ-030 Clean press: btn_in[0] 1->0 held -> btn_state[0]=1 and btn_rise[0]=1 for one cycle, exactly 6 clocks after the first sampling edge; btn_state[1]=0; event_pending[0]=1; irq=1.
REQ-031 Bounce: btn_in[0] low 3 cycles, high 1 cycle, then low held -> no pulse during the bounce; btn_state[0] rises 6 clocks after the final falling sample.
REQ-032 Release: from pressed, btn_in[0] 0->1 held -> btn_fall[0] one-cycle pulse 6 clocks later; event_pending[0] unchanged.
REQ-033 Clear race: event_clr[0]=1 held across a new btn_rise[0] -> event_pending[0]=1 in the following cycle, then 0 on the next cycle with event_clr still 1.
REQ-034 Reset mid-count: press held, resetn pulsed low at count 2 -> no btn_rise; after release, btn_rise[0] occurs 6 clocks later.
